rsa_dec_sequencer: RTL

Input sequencer that sits directly upstream of `rsa_decoder`. It accepts a stream of ciphertext words on a valid/ready interface and buffers them in a small FIFO. It issues one start/done transaction per word to the decoder and presents each recovered plaintext word on a valid/ready output. This lets the decoder's level-held `start` / `done` protocol be driven from any streaming producer without the producer tracking decoder busy time.

---
 rtl/rsa_pkg.sv | 18 +
 rtl/rsa_sync_fifo.sv | 63 ++++++
 rtl/rsa_dec_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA decode path.
// Holds the input sequencer FSM state encoding and the default word width
// and modulus that must agree between the sequencer and the decoder instance.
package rsa_pkg;

   // Default word width and modulus of the decoder this block feeds
   localparam int          RSA_N_BIT = 12;
   localparam logic [11:0] RSA_N     = 12'd3551;

   // Sequencer FSM states, one decode transaction per pass through them
   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_SETUP,
      SEQ_RUN,
      SEQ_RELEASE
   } seq_state_t;

endpackage

// File: rtl/rsa_sync_fifo.sv
// Single-clock FIFO holding ciphertext words ahead of the decoder.
// The head word is shown on 'head' whenever the FIFO is not empty.
// A push while full or a pop while empty is ignored.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   : write request and the word to write
//   pop               : remove the head word
//   full, empty       : occupancy flags
//   head              : word at the head of the FIFO
module rsa_sync_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty can be told apart
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // Pointer update; push and pop in the same cycle both take effect
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

   // Storage needs no reset; stale entries are never visible while empty
   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/rsa_dec_sequencer.sv
// Streaming front end for rsa_decoder.
// Buffers ciphertext words from a valid/ready producer, runs one
// start/done transaction per word on the decoder, and presents each
// plaintext word on a valid/ready output. A new decode is started only
// when the previous result has been taken, so results are never lost.
// Build option: define RSA_RANGE_CHECK_EN to drop words >= N at the input
// (err_range pulses, err_cnt counts); otherwise every word is decoded and
// err_range / err_cnt are held at 0.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid, in_ready, in_data : ciphertext input stream
//   out_valid, out_ready, out_data : plaintext output stream
//   dec_start, dec_data_in      : to decoder start / data_in
//   dec_data_out, dec_done      : from decoder data_out / done
//   busy                        : FSM active or words waiting
//   err_range, err_cnt          : dropped-word pulse and saturating count
module rsa_dec_sequencer
   import rsa_pkg::*;
#(
   parameter int               N_BIT = RSA_N_BIT,
   parameter logic [N_BIT-1:0] N     = N_BIT'(RSA_N),
   parameter int               DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_BIT-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_BIT-1:0] out_data,
   output logic             dec_start,
   output logic [N_BIT-1:0] dec_data_in,
   input  logic [N_BIT-1:0] dec_data_out,
   input  logic             dec_done,
   output logic             busy,
   output logic             err_range,
   output logic [7:0]       err_cnt
);

   seq_state_t       state;
   logic [N_BIT-1:0] op_reg;
   logic             ready_en;
   logic             accept;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [N_BIT-1:0] fifo_head;

   // ready_en keeps in_ready low until the first clock after reset is released
   assign in_ready = ready_en && !rst && !fifo_full;
   assign accept   = in_valid && in_ready;

`ifdef RSA_RANGE_CHECK_EN
   logic out_of_range;

   // An out-of-range word is still handshaken, so the producer never stalls on it
   assign out_of_range = (in_data >= N);
   assign fifo_push    = accept && !out_of_range;
   assign err_range    = accept && out_of_range;

   // Dropped-word counter, sticks at 255
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= 8'd0;
      end else if (err_range && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`else
   logic unused_range_param;

   assign fifo_push          = accept;
   assign err_range          = 1'b0;
   assign err_cnt            = 8'd0;
   assign unused_range_param = ^N;
`endif

   // Pop only when idle and the output register is free: this is the back-pressure point
   assign fifo_pop    = (state == SEQ_IDLE) && !fifo_empty && !out_valid;
   assign dec_data_in = op_reg;
   assign busy        = (state != SEQ_IDLE) || !fifo_empty;

   rsa_sync_fifo #(
      .WIDTH (N_BIT),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (in_data),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   // Decode sequencing: IDLE pops, SETUP presents the operand with start low,
   // RUN holds start until done, RELEASE waits for done to drop again.
   // out_valid is cleared by the consumer handshake; it is only ever set in
   // RUN, which cannot be reached while out_valid is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SEQ_IDLE;
         op_reg    <= '0;
         dec_start <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         ready_en  <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            SEQ_IDLE: begin
               if (fifo_pop) begin
                  op_reg <= fifo_head;
                  state  <= SEQ_SETUP;
               end
            end
            SEQ_SETUP: begin
               dec_start <= 1'b1;
               state     <= SEQ_RUN;
            end
            SEQ_RUN: begin
               if (dec_done) begin
                  out_data  <= dec_data_out;
                  out_valid <= 1'b1;
                  dec_start <= 1'b0;
                  state     <= SEQ_RELEASE;
               end
            end
            SEQ_RELEASE: begin
               if (!dec_done) begin
                  state <= SEQ_IDLE;
               end
            end
            default: begin
               dec_start <= 1'b0;
               state     <= SEQ_IDLE;
            end
         endcase
      end
   end

endmodule
